// File: rtl/adder_tree_stream.sv
// rtl/adder_tree_stream.sv - pipelined N-input adder tree with valid/ready streaming and frame accumulate
module adder_tree_stream #(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int SIGNED  = 0,
  parameter int ACC_EXT = 4,
  parameter int L       = $clog2(N)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N*W-1:0]           in_data,
  input  logic                     in_acc,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W+L+ACC_EXT-1:0]   out_data,
  output logic                     out_ovf
);

  localparam int P     = 2**L;
  localparam int SUM_W = W + L;
  localparam int OUT_W = SUM_W + ACC_EXT;

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic [P*W-1:0] padded;
  assign padded = (P*W)'(in_data);

  // Stage 0 is the combinational input view; stages 1..L each halve the operand count.
  for (genvar s = 0; s <= L; s++) begin : g_st
    localparam int CNT = 2**(L-s);
    localparam int SW  = W + s;
    logic [SW-1:0] d [CNT];
    logic          v;
    logic          a;
    logic          l;

    if (s == 0) begin : g_in
      always_comb begin
        for (int k = 0; k < CNT; k++) d[k] = padded[k*W +: W];
      end
      assign v = in_valid;
      assign a = in_acc;
      assign l = in_last;
    end else begin : g_add
      always_ff @(posedge clk) begin
        if (rst) v <= 1'b0;
        else if (adv) v <= g_st[s-1].v;
        if (adv) begin
          a <= g_st[s-1].a;
          l <= g_st[s-1].l;
          for (int k = 0; k < CNT; k++) begin
            if (SIGNED != 0)
              d[k] <= SW'($signed(g_st[s-1].d[2*k])) + SW'($signed(g_st[s-1].d[2*k+1]));
            else
              d[k] <= SW'(g_st[s-1].d[2*k]) + SW'(g_st[s-1].d[2*k+1]);
          end
        end
      end
    end
  end

  logic [SUM_W-1:0] s_tree;
  logic             s_v;
  logic             s_a;
  logic             s_l;
  assign s_tree = g_st[L].d[0];
  assign s_v    = g_st[L].v;
  assign s_a    = g_st[L].a;
  assign s_l    = g_st[L].l;

  logic [OUT_W-1:0] s_ext;
  logic [OUT_W-1:0] run;
  logic [OUT_W-1:0] acc_sum;
  logic [OUT_W:0]   acc_wide;
  logic             acc_ovf;
  logic             ovf_run;

  always_comb begin
    s_ext    = (SIGNED != 0) ? OUT_W'($signed(s_tree)) : OUT_W'(s_tree);
    acc_wide = {1'b0, run} + {1'b0, s_ext};
    acc_sum  = acc_wide[OUT_W-1:0];
    if (SIGNED != 0)
      acc_ovf = (run[OUT_W-1] == s_ext[OUT_W-1]) && (acc_sum[OUT_W-1] != run[OUT_W-1]);
    else
      acc_ovf = acc_wide[OUT_W];
  end

  // Standalone beats bypass the running sum so an open frame survives them.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      run       <= '0;
      ovf_run   <= 1'b0;
    end else if (adv) begin
      out_valid <= 1'b0;
      if (s_v) begin
        if (!s_a) begin
          out_data  <= s_ext;
          out_ovf   <= 1'b0;
          out_valid <= 1'b1;
        end else if (!s_l) begin
          run     <= acc_sum;
          ovf_run <= ovf_run | acc_ovf;
        end else begin
          out_data  <= acc_sum;
          out_ovf   <= ovf_run | acc_ovf;
          out_valid <= 1'b1;
          run       <= '0;
          ovf_run   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_tree_stream.sv
// tb/tb_adder_tree_stream.sv - scoreboard bench for adder_tree_stream across four configurations
module tb_adder_tree_stream;

  localparam int NI = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid  [NI];
  logic        in_ready  [NI];
  logic        in_acc    [NI];
  logic        in_last   [NI];
  logic        out_valid [NI];
  logic        out_ready [NI];
  logic        out_ovf   [NI];
  logic [39:0] in_data   [NI];
  logic [15:0] od        [NI];

  logic [13:0] od0;
  logic [13:0] od1;
  logic [14:0] od2;
  logic [9:0]  od3;

  // u0: unsigned N=4; u1: signed N=4; u2: unsigned N=5 (padded); u3: unsigned N=4, no headroom
  adder_tree_stream #(.N(4), .W(8), .SIGNED(0), .ACC_EXT(4)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0][31:0]), .in_acc(in_acc[0]), .in_last(in_last[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(od0), .out_ovf(out_ovf[0]));
  adder_tree_stream #(.N(4), .W(8), .SIGNED(1), .ACC_EXT(4)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1][31:0]), .in_acc(in_acc[1]), .in_last(in_last[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(od1), .out_ovf(out_ovf[1]));
  adder_tree_stream #(.N(5), .W(8), .SIGNED(0), .ACC_EXT(4)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .in_acc(in_acc[2]), .in_last(in_last[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(od2), .out_ovf(out_ovf[2]));
  adder_tree_stream #(.N(4), .W(8), .SIGNED(0), .ACC_EXT(0)) u3 (
    .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .in_data(in_data[3][31:0]), .in_acc(in_acc[3]), .in_last(in_last[3]),
    .out_valid(out_valid[3]), .out_ready(out_ready[3]), .out_data(od3), .out_ovf(out_ovf[3]));

  assign od[0] = 16'(od0);
  assign od[1] = 16'($signed(od1));
  assign od[2] = 16'(od2);
  assign od[3] = 16'(od3);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] d;
    logic        o;
    int          c;
  } exp_t;

  exp_t exp_q [NI][$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_mon
    always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid[g] && out_ready[g]) begin
        if (exp_q[g].size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out[%0d]: got %0d required no output", g, od[g]);
        end else begin
          e = exp_q[g].pop_front();
          check($sformatf("data[%0d]", g), {16'd0, od[g]}, {16'd0, e.d});
          check($sformatf("ovf[%0d]", g), {31'd0, out_ovf[g]}, {31'd0, e.o});
          if (e.c >= 0) check($sformatf("latency[%0d]", g), cyc, e.c);
        end
      end
    end
  end

  function automatic logic [39:0] pack4(input logic [7:0] a, b, c, d);
    return {8'd0, d, c, b, a};
  endfunction

  function automatic logic [39:0] pack5(input logic [7:0] a, b, c, d, e);
    return {e, d, c, b, a};
  endfunction

  // lat > 0 also pins the arrival cycle of the result (stall-free cases only).
  task automatic send(input int i, input logic [39:0] d, input logic acc, input logic last,
                      input logic push, input logic [15:0] ed, input logic eo, input int lat);
    int   budget;
    exp_t e;
    budget      = 0;
    in_data[i]  = d;
    in_acc[i]   = acc;
    in_last[i]  = last;
    in_valid[i] = 1'b1;
    @(negedge clk);
    while (!in_ready[i] && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready[i]) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout[%0d]: in_ready=0 required 1", i);
    end
    if (push) begin
      e.d = ed;
      e.o = eo;
      e.c = (lat > 0) ? cyc + lat : -1;
      exp_q[i].push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid[i] = 1'b0;
  endtask

  task automatic wait_drain();
    int b;
    int left;
    b    = 0;
    left = exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size();
    while (left != 0 && b < 200) begin
      @(negedge clk);
      b++;
      left = exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size();
    end
    check("drain_pending", left, 0);
    for (int i = 0; i < NI; i++) exp_q[i].delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      in_valid[i]  = 1'b0;
      in_acc[i]    = 1'b0;
      in_last[i]   = 1'b0;
      in_data[i]   = '0;
      out_ready[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_out_valid[%0d]", i), {31'd0, out_valid[i]}, 0);
      check($sformatf("rst_in_ready[%0d]", i), {31'd0, in_ready[i]}, 1);
      check($sformatf("rst_out_data[%0d]", i), {16'd0, od[i]}, 0);
      check($sformatf("rst_out_ovf[%0d]", i), {31'd0, out_ovf[i]}, 0);
    end
    @(posedge clk);
    #1;

    send(0, pack4(255, 255, 255, 255), 0, 0, 1, 16'd1020, 0, 3);
    send(0, pack4(1, 2, 3, 4),         0, 0, 1, 16'd10,   0, 3);

    send(1, pack4(8'h80, 8'h80, 8'h7f, 8'h01), 0, 0, 1, 16'hFF80, 0, 3);
    send(1, pack4(8'hff, 8'hff, 8'hff, 8'hff), 0, 0, 1, 16'hFFFC, 0, 3);
    send(1, pack4(127, 127, 127, 127),         0, 0, 1, 16'd508,  0, 3);

    send(2, pack5(1, 2, 3, 4, 5),           0, 0, 1, 16'd15,   0, 4);
    send(2, pack5(255, 255, 255, 255, 255), 0, 0, 1, 16'd1275, 0, 4);
    wait_drain();

    send(0, pack4(1, 1, 1, 1), 1, 0, 0, 16'd0,  0, 0);
    send(0, pack4(1, 1, 1, 1), 1, 0, 0, 16'd0,  0, 0);
    send(0, pack4(1, 1, 1, 1), 1, 1, 1, 16'd12, 0, 3);
    wait_drain();

    send(0, pack4(1, 1, 1, 1),  1, 0, 0, 16'd0,  0, 0);
    send(0, pack4(10, 0, 0, 0), 0, 0, 1, 16'd10, 0, 3);
    send(0, pack4(2, 2, 2, 2),  1, 1, 1, 16'd12, 0, 3);
    wait_drain();

    fork
      begin
        repeat (3) @(posedge clk);
        #2;
        out_ready[0] = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("bp_out_valid", {31'd0, out_valid[0]}, 1);
        check("bp_in_ready", {31'd0, in_ready[0]}, 0);
        check("bp_hold_data", {16'd0, od[0]}, 4);
        @(posedge clk);
        #2;
        out_ready[0] = 1'b1;
      end
      begin
        for (int k = 1; k <= 8; k++)
          send(0, pack4(8'(k), 8'(k), 8'(k), 8'(k)), 0, 0, 1, 16'(4*k), 0, 0);
      end
    join
    wait_drain();

    send(3, pack4(255, 255, 255, 255), 1, 0, 0, 16'd0,    0, 0);
    send(3, pack4(255, 255, 255, 255), 1, 1, 1, 16'd1016, 1, 3);
    wait_drain();

    send(3, pack4(255, 255, 255, 255), 1, 0, 0, 16'd0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rerst_out_valid", {31'd0, out_valid[3]}, 0);
    check("rerst_in_ready", {31'd0, in_ready[3]}, 1);
    @(posedge clk);
    #1;
    send(3, pack4(1, 1, 1, 1), 1, 1, 1, 16'd4, 0, 3);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
